multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//  Moore-style FSM that sequences a multicycle MIPS datapath (shared memory, IR, A/B/ALUOut/MDR regs).
//  Replaces the single-cycle combinational decoder: one instruction spans 3-5 cycles, each cycle
//  driving enables/selects for PC, memory, IR, register file and ALU. Sits beside the datapath;
//  its only inputs are the IR opcode and a memory ready handshake.
// PARAMETERS
//  ENABLE_ADDI  1  1: opcode 001000 (addi) supported; 0: treated as illegal
// PORTS
//  clock          in   1  single clock; all state changes on rising edge
//  reset          in   1  synchronous, active-high
//  opcode         in   6  IR[31:26], valid from DECODE onward
//  mem_ready      in   1  memory completes access this cycle
//  pc_write       out  1  unconditional PC load
//  pc_write_cond  out  1  PC load if ALU zero (datapath ANDs with zero)
//  i_or_d         out  1  0: mem addr = PC; 1: mem addr = ALUOut
//  mem_read       out  1  memory read request
//  mem_write      out  1  memory write request
//  ir_write       out  1  IR load
//  mem_to_reg     out  1  1: write-back data = MDR; 0: ALUOut
//  reg_dst        out  1  1: rd (IR[15:11]); 0: rt (IR[20:16])
//  reg_write      out  1  register file write
//  alu_src_a      out  1  0: PC; 1: reg A
//  alu_src_b      out  2  00: B; 01: const 4; 10: sign-ext imm; 11: sign-ext imm<<2
//  alu_op         out  2  00: add; 01: sub; 10: use funct
//  pc_source      out  2  00: ALU result; 01: ALUOut; 10: jump target {PC[31:28],IR[25:0],2'b00}
//  state          out  4  current state (debug/verification)
//  instr_done     out  1  1-cycle pulse on final cycle of every instruction (incl. illegal)
//  illegal_op     out  1  1-cycle pulse in DECODE on unsupported opcode
// BEHAVIOUR
//  Reset: while reset=1, next state=FETCH; all outputs 0 (including FETCH decodes), state=0.
//  States: FETCH0 DECODE1 MEM_ADDR2 MEM_RD3 MEM_WB4 MEM_WR5 EXEC6 R_WB7 BRANCH8 JUMP9 ADDI_EX10 ADDI_WB11.
//  Outputs not listed for a state are 0. Values in {} are asserted in that state.
//  FETCH   {mem_read,i_or_d=0,alu_src_a=0,alu_src_b=01,alu_op=00,pc_source=00};
//          ir_write,pc_write only when mem_ready=1; hold in FETCH while mem_ready=0.
//  DECODE  {alu_src_a=0,alu_src_b=11,alu_op=00} (branch target -> ALUOut); next by opcode:
//          000000->EXEC, 100011/101011->MEM_ADDR, 000100->BRANCH, 000010->JUMP,
//          001000->ADDI_EX (if ENABLE_ADDI), other->FETCH with illegal_op=1, instr_done=1.
//  MEM_ADDR{alu_src_a=1,alu_src_b=10,alu_op=00}; lw->MEM_RD, sw->MEM_WR.
//  MEM_RD  {mem_read,i_or_d=1}; hold while mem_ready=0; ->MEM_WB.
//  MEM_WB  {reg_write,mem_to_reg=1,reg_dst=0,instr_done}; ->FETCH.
//  MEM_WR  {mem_write,i_or_d=1}; hold while mem_ready=0; instr_done when mem_ready=1; ->FETCH.
//  EXEC    {alu_src_a=1,alu_src_b=00,alu_op=10}; ->R_WB.
//  R_WB    {reg_write,reg_dst=1,mem_to_reg=0,instr_done}; ->FETCH.
//  BRANCH  {alu_src_a=1,alu_src_b=00,alu_op=01,pc_write_cond,pc_source=01,instr_done}; ->FETCH.
//  JUMP    {pc_write,pc_source=10,instr_done}; ->FETCH.
//  ADDI_EX {alu_src_a=1,alu_src_b=10,alu_op=00}; ->ADDI_WB.
//  ADDI_WB {reg_write,reg_dst=0,mem_to_reg=0,instr_done}; ->FETCH.
//  Cycle counts (mem_ready=1): R 4, lw 5, sw 4, beq 3, j 3, addi 4; each mem stall cycle adds 1.
//  mem_read/mem_write held stable for the whole stall; no other outputs change during a stall.
//  Unreachable state encodings (12-15): next state FETCH, all outputs 0.
//  Reset mid-instruction: next cycle FETCH, no write enable asserted in the reset cycle.
//  opcode is sampled only in DECODE and MEM_ADDR; changes elsewhere are ignored.
// STRUCTURE
//  Package mc_ctrl_pkg: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI),
//  4-bit state encodings, ALUOp codes, alu_src_b and pc_source select codes.
//  Sub-module mc_ctrl_decode: purely combinational state(+mem_ready)->output decoder;
//  top holds state register and next-state logic only.
// TESTING
//  reset 2 cycles, mem_ready=1, opcode=000000 -> states 0,1,6,7,0; reg_write=1,reg_dst=1 in state 7 only.
//  lw (100011), mem_ready low 2 cycles in MEM_RD -> 0,1,2,3,3,3,4,0; mem_read,i_or_d=1 held 3 cycles.
//  sw (101011) -> 0,1,2,5,0; mem_write=1 exactly 1 cycle; reg_write never 1; instr_done in state 5.
//  beq (000100) then j (000010) -> pc_write_cond+pc_source=01 in 8; pc_write+pc_source=10 in 9; 3 cycles each.
//  opcode 111111 -> illegal_op=1 in DECODE, back to FETCH; ENABLE_ADDI=0 with 001000 -> same.
//  reset asserted in MEM_WB -> next state 0, reg_write=0 in the reset cycle; FETCH stall holds ir_write=0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mc_ctrl_pkg
//  Description : Shared definitions for the multicycle MIPS control unit:
//                opcode constants, 4-bit state encodings, ALU / mux select
//                codes, the bundled control-word type and an opcode
//                legality helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

   // Primary opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   // Sequencer states; encodings 12-15 are unused and recover to FETCH
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_EXEC     = 4'd6,
      S_R_WB     = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_ADDI_EX  = 4'd10,
      S_ADDI_WB  = 4'd11
   } state_e;

   // ALU operation class
   localparam logic [1:0] C_ALUOP_ADD   = 2'b00;
   localparam logic [1:0] C_ALUOP_SUB   = 2'b01;
   localparam logic [1:0] C_ALUOP_FUNCT = 2'b10;

   // ALU B-operand select
   localparam logic [1:0] C_SRCB_REG    = 2'b00;
   localparam logic [1:0] C_SRCB_FOUR   = 2'b01;
   localparam logic [1:0] C_SRCB_IMM    = 2'b10;
   localparam logic [1:0] C_SRCB_IMM_SH = 2'b11;

   // PC source select
   localparam logic [1:0] C_PCSRC_ALU    = 2'b00;
   localparam logic [1:0] C_PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] C_PCSRC_JUMP   = 2'b10;

   // Complete set of datapath controls produced each cycle
   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       instr_done;
      logic       illegal_op;
   } ctrl_t;

   // True when the opcode has a defined execution sequence
   function automatic logic op_supported(input logic [5:0] op, input logic enable_addi);
      logic ok;
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
         OP_ADDI:                              ok = enable_addi;
         default:                              ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module      : mc_ctrl_decode
//  Description : Combinational output decoder for the multicycle control
//                FSM. Maps current state (plus mem_ready for the stalling
//                states and opcode for the DECODE illegal check) to the
//                datapath control word. Reset forces every control to 0.
//  Ports       : i_rst       - reset, masks all outputs
//                i_state     - current sequencer state
//                i_mem_ready - memory access completes this cycle
//                i_opcode    - IR[31:26]
//                o_ctrl      - control word
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl_decode
   import mc_ctrl_pkg::*;
#(
   parameter bit ENABLE_ADDI = 1'b1
) (
   input  logic       i_rst,
   input  state_e     i_state,
   input  logic       i_mem_ready,
   input  logic [5:0] i_opcode,
   output ctrl_t      o_ctrl
);

   always_comb begin
      o_ctrl = '0;
      if (!i_rst) begin
         case (i_state)
            S_FETCH: begin
               o_ctrl.mem_read  = 1'b1;
               o_ctrl.alu_src_b = C_SRCB_FOUR;
               o_ctrl.alu_op    = C_ALUOP_ADD;
               o_ctrl.pc_source = C_PCSRC_ALU;
               // IR and PC only advance once the instruction word arrives
               o_ctrl.ir_write  = i_mem_ready;
               o_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
               // Speculatively compute the branch target into ALUOut
               o_ctrl.alu_src_b  = C_SRCB_IMM_SH;
               o_ctrl.alu_op     = C_ALUOP_ADD;
               o_ctrl.illegal_op = !op_supported(i_opcode, ENABLE_ADDI);
               o_ctrl.instr_done = !op_supported(i_opcode, ENABLE_ADDI);
            end
            S_MEM_ADDR, S_ADDI_EX: begin
               o_ctrl.alu_src_a = 1'b1;
               o_ctrl.alu_src_b = C_SRCB_IMM;
               o_ctrl.alu_op    = C_ALUOP_ADD;
            end
            S_MEM_RD: begin
               o_ctrl.mem_read = 1'b1;
               o_ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
               o_ctrl.reg_write  = 1'b1;
               o_ctrl.mem_to_reg = 1'b1;
               o_ctrl.instr_done = 1'b1;
            end
            S_MEM_WR: begin
               o_ctrl.mem_write  = 1'b1;
               o_ctrl.i_or_d     = 1'b1;
               o_ctrl.instr_done = i_mem_ready;
            end
            S_EXEC: begin
               o_ctrl.alu_src_a = 1'b1;
               o_ctrl.alu_src_b = C_SRCB_REG;
               o_ctrl.alu_op    = C_ALUOP_FUNCT;
            end
            S_R_WB: begin
               o_ctrl.reg_write  = 1'b1;
               o_ctrl.reg_dst    = 1'b1;
               o_ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
               o_ctrl.alu_src_a     = 1'b1;
               o_ctrl.alu_src_b     = C_SRCB_REG;
               o_ctrl.alu_op        = C_ALUOP_SUB;
               o_ctrl.pc_write_cond = 1'b1;
               o_ctrl.pc_source     = C_PCSRC_ALUOUT;
               o_ctrl.instr_done    = 1'b1;
            end
            S_JUMP: begin
               o_ctrl.pc_write   = 1'b1;
               o_ctrl.pc_source  = C_PCSRC_JUMP;
               o_ctrl.instr_done = 1'b1;
            end
            S_ADDI_WB: begin
               o_ctrl.reg_write  = 1'b1;
               o_ctrl.instr_done = 1'b1;
            end
            default: o_ctrl = '0;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Moore-style sequencer for a multicycle MIPS datapath. Holds
//                the state register and next-state logic; control outputs
//                come from mc_ctrl_decode.
//  Ports       : clock, reset (sync, active-high), opcode (IR[31:26]),
//                mem_ready; outputs pc_write, pc_write_cond, i_or_d,
//                mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
//                reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0],
//                pc_source[1:0], state[3:0], instr_done, illegal_op
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
   import mc_ctrl_pkg::*;
#(
   parameter bit ENABLE_ADDI = 1'b1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic [3:0] state,
   output logic       instr_done,
   output logic       illegal_op
);

   state_e state_q;
   state_e state_d;
   ctrl_t  w_ctrl;

   // opcode only matters in DECODE and MEM_ADDR
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_RTYPE:     state_d = S_EXEC;
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_ADDI:      state_d = ENABLE_ADDI ? S_ADDI_EX : S_FETCH;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
         S_MEM_WR:   state_d = mem_ready ? S_FETCH : S_MEM_WR;
         S_EXEC:     state_d = S_R_WB;
         S_ADDI_EX:  state_d = S_ADDI_WB;
         default:    state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   mc_ctrl_decode #(
      .ENABLE_ADDI (ENABLE_ADDI)
   ) u_decode (
      .i_rst       (reset),
      .i_state     (state_q),
      .i_mem_ready (mem_ready),
      .i_opcode    (opcode),
      .o_ctrl      (w_ctrl)
   );

   assign pc_write      = w_ctrl.pc_write;
   assign pc_write_cond = w_ctrl.pc_write_cond;
   assign i_or_d        = w_ctrl.i_or_d;
   assign mem_read      = w_ctrl.mem_read;
   assign mem_write     = w_ctrl.mem_write;
   assign ir_write      = w_ctrl.ir_write;
   assign mem_to_reg    = w_ctrl.mem_to_reg;
   assign reg_dst       = w_ctrl.reg_dst;
   assign reg_write     = w_ctrl.reg_write;
   assign alu_src_a     = w_ctrl.alu_src_a;
   assign alu_src_b     = w_ctrl.alu_src_b;
   assign alu_op        = w_ctrl.alu_op;
   assign pc_source     = w_ctrl.pc_source;
   assign instr_done    = w_ctrl.instr_done;
   assign illegal_op    = w_ctrl.illegal_op;

   // Reported state reads as FETCH while reset is held
   assign state = reset ? 4'd0 : 4'(state_q);

endmodule
`default_nettype wire
